// File: rtl/frame_update_seq_if.sv
// Handshake and status bundle between the frame-update sequencer and the
// breakout physics sub-blocks / VGA timing source.
interface frame_update_seq_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [1:0] game_state;
    logic       game_reset;
    logic       racket_req;
    logic       racket_ack;
    logic       ball_req;
    logic       ball_ack;
    logic       brick_req;
    logic       brick_ack;
    logic       frame_tick;
    logic       seq_done;
    logic       busy;
    logic       timeout_err;
    logic [7:0] overrun_cnt;

    modport master (
        input  pix_x, pix_y, game_state, game_reset,
        input  racket_ack, ball_ack, brick_ack,
        output racket_req, ball_req, brick_req,
        output frame_tick, seq_done, busy, timeout_err, overrun_cnt
    );

    modport slave (
        output pix_x, pix_y, game_state, game_reset,
        output racket_ack, ball_ack, brick_ack,
        input  racket_req, ball_req, brick_req,
        input  frame_tick, seq_done, busy, timeout_err, overrun_cnt
    );
endinterface

// File: rtl/frame_update_seq.sv
// Per-frame game-update sequencer: at the start of vertical blanking it runs
// racket, ball and brick updates in order via req/ack, with timeout and overrun tracking.
module frame_update_seq #(
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SPEED_DIV   = 1,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    frame_update_seq_if.master bus
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned TO_W  = 10;
    localparam int unsigned OVR_W = 8;
    localparam int unsigned PIX_W = 10;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [PIX_W-1:0] V_LINE   = PIX_W'(V_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RACKET,
        S_BALL,
        S_BRICK,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_follow;
    logic               w_stage;
    logic               w_ack;
    logic               w_timeout;
    logic               w_match;
    logic               w_play;
    logic               w_launch;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_frame_tick;
    logic               r_racket_req;
    logic               r_ball_req;
    logic               r_brick_req;
    logic               r_seq_done;
    logic               r_busy;
    logic               r_timeout_err;
    logic [OVR_W-1:0]   r_overrun_cnt;

    // Blanking-start detect; acted on at the same edge that registers frame_tick.
    assign w_match  = (bus.pix_x == '0) && (bus.pix_y == V_LINE);
    assign w_play   = (bus.game_state == 2'b01);
    assign w_launch = w_match && w_play && (r_div_cnt == '0) && !bus.game_reset;

    always_comb begin
        w_next    = r_state;
        w_follow  = S_IDLE;
        w_stage   = 1'b0;
        w_ack     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (w_launch) w_next = S_RACKET;
            S_RACKET: begin
                w_stage  = 1'b1;
                w_ack    = bus.racket_ack;
                w_follow = S_BALL;
            end
            S_BALL: begin
                w_stage  = 1'b1;
                w_ack    = bus.ball_ack;
                w_follow = S_BRICK;
            end
            S_BRICK: begin
                w_stage  = 1'b1;
                w_ack    = bus.brick_ack;
                w_follow = S_DONE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // An ack on the last allowed cycle still wins over the timeout.
        if (w_stage) begin
            if (w_ack) begin
                w_next = w_follow;
            end else if (r_to_cnt == TO_LAST) begin
                w_next    = S_IDLE;
                w_timeout = 1'b1;
            end
        end
        if (bus.game_reset) begin
            w_next    = S_IDLE;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Outputs decode the next state so each req lines up with its state.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_tick  <= 1'b0;
            r_racket_req  <= 1'b0;
            r_ball_req    <= 1'b0;
            r_brick_req   <= 1'b0;
            r_seq_done    <= 1'b0;
            r_busy        <= 1'b0;
            r_to_cnt      <= '0;
            r_div_cnt     <= '0;
            r_timeout_err <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            r_frame_tick <= w_match;
            r_racket_req <= (w_next == S_RACKET);
            r_ball_req   <= (w_next == S_BALL);
            r_brick_req  <= (w_next == S_BRICK);
            r_seq_done   <= (w_next == S_DONE);
            r_busy       <= (w_next != S_IDLE);
            r_to_cnt     <= (w_stage && (w_next == r_state)) ? r_to_cnt + 1'b1 : '0;

            if (bus.game_reset || !w_play) begin
                r_div_cnt <= '0;
            end else if (w_match) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            end

            if (bus.game_reset)  r_timeout_err <= 1'b0;
            else if (w_timeout)  r_timeout_err <= 1'b1;

            if (bus.game_reset) begin
                r_overrun_cnt <= '0;
            end else if (w_match && (r_state != S_IDLE) && (r_overrun_cnt != '1)) begin
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_tick  = r_frame_tick;
    assign bus.racket_req  = r_racket_req;
    assign bus.ball_req    = r_ball_req;
    assign bus.brick_req   = r_brick_req;
    assign bus.seq_done    = r_seq_done;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun_cnt = r_overrun_cnt;
endmodule
